// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the slave state type used by the SRAM slave
// and any later AHB-Lite slaves that reuse the byte-lane decoder.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahbl_state_e;

    // True for transfer types that start a real access.
    function automatic logic trans_active(input logic [1:0] htrans);
        logic r;
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahbl_bytelane_dec.sv
// Maps (size, addr[1:0]) to a little-endian byte strobe and flags sizes or
// alignments a 32-bit AHB-Lite slave cannot serve.
import ahbl_pkg::*;

module ahbl_bytelane_dec (
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr,
    output logic [3:0] o_strb,
    output logic       o_illegal
);

    always_comb begin
        o_strb    = 4'b0000;
        o_illegal = 1'b0;
        case (i_size)
            HSIZE_BYTE: o_strb = 4'b0001 << i_addr;
            HSIZE_HALF: begin
                o_strb    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_illegal = i_addr[0];
            end
            HSIZE_WORD: begin
                o_strb    = 4'b1111;
                o_illegal = |i_addr;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM slave model: word array, programmable wait states, two-cycle
// ERROR response for illegal accesses and saturating transfer counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no transfer, or final (zero-wait) data phase of a legal one
//   ST_WAIT | legal data phase; HREADYOUT low until wait counter hits 0
//   ST_ERR1 | first ERROR cycle (HREADYOUT=0, HRESP=1)
//   ST_ERR2 | second ERROR cycle (HREADYOUT=1, HRESP=1); may accept
import ahbl_pkg::*;

module ahbl_sram_slave #(
    parameter int AWIDTH      = 12,
    parameter int WAIT_STATES = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [3:0]           HPROT,
    input  logic                 HMASTLOCK,
    input  logic                 HREADY,
    input  logic [31:0]          HWDATA,
    output logic [31:0]          HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [CNT_WIDTH-1:0] WR_CNT,
    output logic [CNT_WIDTH-1:0] RD_CNT
);

    localparam int DEPTH = 2 ** (AWIDTH - 2);

    logic [31:0]          r_mem [DEPTH];
    ahbl_state_e          r_state;
    ahbl_state_e          w_next_state;
    logic [AWIDTH-1:0]    r_addr;
    logic                 r_write;
    logic [2:0]           r_size;
    logic                 r_active;
    logic [3:0]           r_wcnt;
    logic [CNT_WIDTH-1:0] r_wr_cnt;
    logic [CNT_WIDTH-1:0] r_rd_cnt;

    logic       w_accept;
    logic       w_illegal;
    logic       w_ready;
    logic       w_resp;
    logic       w_final;
    logic [3:0] w_strb;
    logic [3:0] w_bus_strb;
    logic       w_reg_illegal;
    logic       w_unused;

    assign w_accept = HSEL & HREADY & trans_active(HTRANS);

    ahbl_bytelane_dec u_bus_dec (
        .i_size    (HSIZE),
        .i_addr    (HADDR[1:0]),
        .o_strb    (w_bus_strb),
        .o_illegal (w_illegal)
    );

    ahbl_bytelane_dec u_reg_dec (
        .i_size    (r_size),
        .i_addr    (r_addr[1:0]),
        .o_strb    (w_strb),
        .o_illegal (w_reg_illegal)
    );

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b1;
        w_resp       = HRESP_OKAY;
        case (r_state)
            ST_WAIT: w_ready = (r_wcnt == 4'd0);
            ST_ERR1: begin
                w_ready = 1'b0;
                w_resp  = HRESP_ERROR;
            end
            ST_ERR2: w_resp = HRESP_ERROR;
            default: ;
        endcase
        if (r_state == ST_ERR1) begin
            w_next_state = ST_ERR2;
        end else if (w_ready) begin
            if (w_accept && w_illegal)
                w_next_state = ST_ERR1;
            else if (w_accept && (WAIT_STATES > 0))
                w_next_state = ST_WAIT;
            else
                w_next_state = ST_IDLE;
        end
    end

    // r_active only ever set in IDLE/WAIT, so this is the closing OKAY cycle.
    assign w_final = r_active & w_ready;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_size   <= HSIZE_BYTE;
            r_active <= 1'b0;
            r_wcnt   <= 4'd0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ready) begin
                r_active <= w_accept & ~w_illegal;
                if (w_accept) begin
                    r_addr  <= HADDR[AWIDTH-1:0];
                    r_write <= HWRITE;
                    r_size  <= HSIZE;
                end
                if (w_accept && !w_illegal)
                    r_wcnt <= 4'(WAIT_STATES);
            end else if (r_state == ST_WAIT) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_final && r_write && (r_wr_cnt != '1))
                r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
            if (w_final && !r_write && (r_rd_cnt != '1))
                r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge HCLK) begin
        if (w_final && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i])
                    r_mem[r_addr[AWIDTH-1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA    = (r_active && !r_write) ? r_mem[r_addr[AWIDTH-1:2]] : 32'h0;
    assign HREADYOUT = w_ready;
    assign HRESP     = w_resp;
    assign WR_CNT    = r_wr_cnt;
    assign RD_CNT    = r_rd_cnt;

    assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:AWIDTH], w_bus_strb, w_reg_illegal};

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave: one zero-wait and one three-wait instance
// share the address/data bus and are selected one at a time.
import ahbl_pkg::*;

module tb_ahbl_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0, sel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;

    logic [31:0] rdata0, rdata3;
    logic        rdy0, rdy3, resp0, resp3;
    logic [15:0] wr0, rd0, wr3, rd3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ahbl_sram_slave #(.AWIDTH(12), .WAIT_STATES(0), .CNT_WIDTH(16)) u_dut0 (
        .HCLK(clk), .HRESETN(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HREADY(rdy0), .HWDATA(hwdata), .HRDATA(rdata0),
        .HREADYOUT(rdy0), .HRESP(resp0), .WR_CNT(wr0), .RD_CNT(rd0)
    );

    ahbl_sram_slave #(.AWIDTH(12), .WAIT_STATES(3), .CNT_WIDTH(16)) u_dut3 (
        .HCLK(clk), .HRESETN(rst_n), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HMASTLOCK(hmastlock), .HREADY(rdy3), .HWDATA(hwdata), .HRDATA(rdata3),
        .HREADYOUT(rdy3), .HRESP(resp3), .WR_CNT(wr3), .RD_CNT(rd3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one bus cycle (address phase of this transfer, write data of the
    // previous one), then returns 1 time unit after the rising edge.
    task automatic drv(input logic s0, input logic s3, input logic [1:0] t,
                       input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        sel0   = s0;
        sel3   = s3;
        htrans = t;
        hwrite = w;
        hsize  = sz;
        haddr  = a;
        hwdata = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sel0      = 1'b0;
        sel3      = 1'b0;
        haddr     = 32'h0;
        htrans    = HTRANS_IDLE;
        hwrite    = 1'b0;
        hsize     = HSIZE_WORD;
        hburst    = 3'b000;
        hprot     = 4'b0011;
        hmastlock = 1'b0;
        hwdata    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy0", {31'b0, rdy0}, 32'h1);
        chk("rst_resp0", {31'b0, resp0}, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_wr0", {16'b0, wr0}, 32'h0);
        chk("rst_rd0", {16'b0, rd0}, 32'h0);
        chk("rst_rdy3", {31'b0, rdy3}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait write then back-to-back read of 0x010
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h010, 32'h0);
        chk("wr_rdy", {31'b0, rdy0}, 32'h1);
        chk("wr_rdata_zero", rdata0, 32'h0);
        drv(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h010, 32'hDEADBEEF);
        chk("b2b_rdata", rdata0, 32'hDEADBEEF);
        chk("b2b_rdy", {31'b0, rdy0}, 32'h1);
        chk("b2b_wrcnt", {16'b0, wr0}, 32'd1);
        drv(1, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        chk("b2b_rdcnt", {16'b0, rd0}, 32'd1);
        chk("idle_rdata", rdata0, 32'h0);

        // Byte lanes, then a halfword into the upper half
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h020, 32'h0);
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h021, 32'hEEEEEE11);
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h022, 32'hEEEE22EE);
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h023, 32'hEE33EEEE);
        drv(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h020, 32'h44EEEEEE);
        chk("byte_word", rdata0, 32'h44332211);
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h022, 32'h0);
        drv(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h020, 32'hABCD1234);
        chk("half_word", rdata0, 32'hABCD2211);
        drv(1, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        chk("byte_wrcnt", {16'b0, wr0}, 32'd6);
        chk("byte_rdcnt", {16'b0, rd0}, 32'd3);

        // Misaligned word and HSIZE=3, each a two-cycle ERROR
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h000, 32'h0);
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h002, 32'hCAFEF00D);
        chk("mis_err1_rdy", {31'b0, rdy0}, 32'h0);
        chk("mis_err1_resp", {31'b0, resp0}, 32'h1);
        drv(1, 0, HTRANS_NONSEQ, 1, 3'd3, 32'h000, 32'h11111111);
        chk("mis_err2_rdy", {31'b0, rdy0}, 32'h1);
        chk("mis_err2_resp", {31'b0, resp0}, 32'h1);
        drv(1, 0, HTRANS_NONSEQ, 1, 3'd3, 32'h000, 32'h22222222);
        chk("sz3_err1_rdy", {31'b0, rdy0}, 32'h0);
        chk("sz3_err1_resp", {31'b0, resp0}, 32'h1);
        drv(1, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h000, 32'h33333333);
        chk("sz3_err2_rdy", {31'b0, rdy0}, 32'h1);
        chk("sz3_err2_resp", {31'b0, resp0}, 32'h1);
        drv(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h000, 32'h0);
        chk("err_after_resp", {31'b0, resp0}, 32'h0);
        chk("err_word0", rdata0, 32'hCAFEF00D);
        drv(1, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        chk("err_wrcnt", {16'b0, wr0}, 32'd7);
        chk("err_rdcnt", {16'b0, rd0}, 32'd4);

        // SEQ burst with BUSY and unselected cycles interleaved
        hburst = 3'b011;
        drv(1, 0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h100, 32'h0);
        drv(1, 0, HTRANS_BUSY, 1, HSIZE_WORD, 32'h104, 32'h0000A000);
        chk("busy_rdy", {31'b0, rdy0}, 32'h1);
        chk("busy_resp", {31'b0, resp0}, 32'h0);
        drv(1, 0, HTRANS_SEQ, 1, HSIZE_WORD, 32'h104, 32'hFFFFFFFF);
        drv(0, 0, HTRANS_SEQ, 1, HSIZE_WORD, 32'h108, 32'h0000A001);
        chk("unsel_rdy", {31'b0, rdy0}, 32'h1);
        chk("unsel_resp", {31'b0, resp0}, 32'h0);
        drv(1, 0, HTRANS_SEQ, 1, HSIZE_WORD, 32'h108, 32'h55555555);
        drv(1, 0, HTRANS_SEQ, 1, HSIZE_WORD, 32'h10C, 32'h0000A002);
        drv(1, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0000A003);
        chk("burst_wrcnt", {16'b0, wr0}, 32'd11);
        drv(1, 0, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h100, 32'h0);
        chk("burst_rd0", rdata0, 32'h0000A000);
        drv(1, 0, HTRANS_SEQ, 0, HSIZE_WORD, 32'h104, 32'h0);
        chk("burst_rd1", rdata0, 32'h0000A001);
        drv(1, 0, HTRANS_SEQ, 0, HSIZE_WORD, 32'h108, 32'h0);
        chk("burst_rd2", rdata0, 32'h0000A002);
        drv(1, 0, HTRANS_SEQ, 0, HSIZE_WORD, 32'h10C, 32'h0);
        chk("burst_rd3", rdata0, 32'h0000A003);
        drv(1, 0, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        chk("burst_rdcnt", {16'b0, rd0}, 32'd8);
        hburst = 3'b000;

        // Three wait states: write 0x040, then read with a second read held
        drv(0, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h040, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("ws_wr_low", {31'b0, rdy3}, 32'h0);
            drv(0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h040, 32'h600DF00D);
        end
        chk("ws_wr_final", {31'b0, rdy3}, 32'h1);
        drv(0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h040, 32'h600DF00D);
        chk("ws_wrcnt", {16'b0, wr3}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("ws_rd_low", {31'b0, rdy3}, 32'h0);
            chk("ws_rd_data_wait", rdata3, 32'h600DF00D);
            drv(0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h040, 32'h0);
        end
        chk("ws_rd_final", {31'b0, rdy3}, 32'h1);
        chk("ws_rd_data", rdata3, 32'h600DF00D);
        chk("ws_rdcnt_pre", {16'b0, rd3}, 32'd0);
        drv(0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h040, 32'h0);
        chk("ws_held_accept", {31'b0, rdy3}, 32'h0);
        chk("ws_rdcnt1", {16'b0, rd3}, 32'd1);
        for (int i = 0; i < 3; i++)
            drv(0, 1, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        chk("ws_rd2_final", {31'b0, rdy3}, 32'h1);
        drv(0, 1, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        chk("ws_rdcnt2", {16'b0, rd3}, 32'd2);
        chk("ws_idle_rdata", rdata3, 32'h0);

        // Reset asserted in the middle of a waited write
        drv(0, 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h040, 32'h0);
        drv(0, 1, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h12345678);
        chk("mid_wait_low", {31'b0, rdy3}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", {31'b0, rdy3}, 32'h1);
        chk("arst_resp", {31'b0, resp3}, 32'h0);
        chk("arst_rdata", rdata3, 32'h0);
        chk("arst_wrcnt", {16'b0, wr3}, 32'd0);
        chk("arst_rdcnt", {16'b0, rd3}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drv(0, 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h040, 32'h12345678);
        for (int i = 0; i < 3; i++)
            drv(0, 1, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h12345678);
        chk("post_rst_rdy", {31'b0, rdy3}, 32'h1);
        chk("post_rst_word", rdata3, 32'h600DF00D);
        drv(0, 1, HTRANS_IDLE, 0, HSIZE_WORD, 32'h0, 32'h0);
        chk("post_rst_rdcnt", {16'b0, rd3}, 32'd1);
        chk("post_rst_wrcnt", {16'b0, wr3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
